// File: rtl/fft8_stage_ctrl_pkg.sv
// Shared types and constants for the 8-point FFT stage-1 control slice.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fft8_pkg;

    localparam int FFT8_LEN    = 8;
    localparam int FFT8_HALF   = 4;
    localparam int FFT8_TW_LAT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BFLY  = 2'd2,
        DRAIN = 2'd3
    } fft8_ctrl_state_t;

endpackage

// File: rtl/fft8_stage_ctrl_if.sv
// Handshake and control bundle between upstream, the stage sequencer and the datapath.
// Latency: none (wires only); frame_cnt exists only with FFT8_CTRL_FRAME_CNT_EN.
// Backpressure: in_valid/in_ready on the sample side; control outputs are not stallable.
interface fft8_stage_ctrl_if;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       dl_shift;
    logic       bf_en;
    logic       out_sel;
    logic       out_valid;
    logic       out_last;
    logic       rotator_valid;
    logic [1:0] tw_idx;
    logic       frame_err;
`ifdef FFT8_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    modport slave (
        input  in_valid, in_last,
        output in_ready, dl_shift, bf_en, out_sel, out_valid, out_last,
               rotator_valid, tw_idx, frame_err, frame_cnt
    );
    modport master (
        output in_valid, in_last,
        input  in_ready, dl_shift, bf_en, out_sel, out_valid, out_last,
               rotator_valid, tw_idx, frame_err, frame_cnt
    );
`else
    modport slave (
        input  in_valid, in_last,
        output in_ready, dl_shift, bf_en, out_sel, out_valid, out_last,
               rotator_valid, tw_idx, frame_err
    );
    modport master (
        output in_valid, in_last,
        input  in_ready, dl_shift, bf_en, out_sel, out_valid, out_last,
               rotator_valid, tw_idx, frame_err
    );
`endif
endinterface

// File: rtl/fft8_stage_ctrl_frame_checker.sv
// Flags an in_last that disagrees with the sample count of the frame.
// Latency: frame_err is a one-cycle pulse the cycle after the offending accept.
// Backpressure: none; only observes accepts.
module fft8_frame_checker (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic in_last,
    input  logic last_expected,
    output logic frame_err
);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & (in_last != last_expected);
        end
    end

endmodule

// File: rtl/fft8_stage_ctrl.sv
// Sequencer for the first radix-2 SDF stage of the 8-point FFT; optional frame counter under FFT8_CTRL_FRAME_CNT_EN.
// Latency: controls are combinational from state; 12 cycles per unstalled frame (8 accepts + 4 drain).
// Backpressure: in_valid stalls hold FILL/BFLY; DRAIN is self-timed with in_ready low.
module fft8_stage_ctrl
    import fft8_pkg::*;
#(
    parameter int FRAME_LEN = FFT8_LEN,
    parameter int HALF_LEN  = FFT8_HALF
) (
    input  logic             clk,
    input  logic             rst,
    fft8_stage_ctrl_if.slave bus
);

    localparam logic [2:0] FILL_LAST  = 3'(HALF_LEN - 1);
    localparam logic [2:0] FRAME_LAST = 3'(FRAME_LEN - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(HALF_LEN - 1);
    // The memory is fed one cycle ahead, so its strobe ends FFT8_TW_LAT cycles before DRAIN does.
    localparam logic [1:0] ROT_END    = 2'(HALF_LEN - FFT8_TW_LAT);

    fft8_ctrl_state_t state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       dcnt_q, dcnt_d;

    logic       accept;
    logic       in_ready;
    logic       dl_shift;
    logic       bf_en;
    logic       out_sel;
    logic       out_valid;
    logic       out_last;
    logic       rotator_valid;
    logic [1:0] tw_idx;
    logic       last_expected;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            dcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dcnt_d        = dcnt_q;
        accept        = 1'b0;
        in_ready      = 1'b0;
        dl_shift      = 1'b0;
        bf_en         = 1'b0;
        out_sel       = 1'b0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        rotator_valid = 1'b0;
        tw_idx        = 2'd0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    accept   = bus.in_valid;
                    if (accept) begin
                        dl_shift = 1'b1;
                        cnt_d    = 3'd1;
                        state_d  = FILL;
                    end
                end
                FILL: begin
                    in_ready = 1'b1;
                    accept   = bus.in_valid;
                    if (accept) begin
                        dl_shift = 1'b1;
                        cnt_d    = cnt_q + 3'd1;
                        if (cnt_q == FILL_LAST) begin
                            state_d = BFLY;
                        end
                    end
                end
                BFLY: begin
                    in_ready = 1'b1;
                    accept   = bus.in_valid;
                    if (accept) begin
                        dl_shift  = 1'b1;
                        bf_en     = 1'b1;
                        out_valid = 1'b1;
                        cnt_d     = cnt_q + 3'd1;
                        if (cnt_q == FRAME_LAST) begin
                            rotator_valid = 1'b1;
                            cnt_d         = 3'd0;
                            state_d       = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    dl_shift      = 1'b1;
                    out_valid     = 1'b1;
                    out_sel       = 1'b1;
                    tw_idx        = dcnt_q;
                    rotator_valid = (dcnt_q < ROT_END);
                    dcnt_d        = dcnt_q + 2'd1;
                    if (dcnt_q == DRAIN_LAST) begin
                        out_last = 1'b1;
                        dcnt_d   = 2'd0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign last_expected = (state_q == BFLY) && (cnt_q == FRAME_LAST);

    fft8_frame_checker u_frame_checker (
        .clk          (clk),
        .rst          (rst),
        .accept       (accept),
        .in_last      (bus.in_last),
        .last_expected(last_expected),
        .frame_err    (bus.frame_err)
    );

`ifdef FFT8_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else if (out_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

    assign bus.in_ready      = in_ready;
    assign bus.dl_shift      = dl_shift;
    assign bus.bf_en         = bf_en;
    assign bus.out_sel       = out_sel;
    assign bus.out_valid     = out_valid;
    assign bus.out_last      = out_last;
    assign bus.rotator_valid = rotator_valid;
    assign bus.tw_idx        = tw_idx;

endmodule
